// File: rtl/up_mod_counter_if.sv
// Control and status bundle for up_mod_counter.
// master drives controls; slave is the counter.
interface up_mod_counter_if #(
  parameter int WIDTH = 3,
  parameter int WRAPW = 8
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic [WRAPW-1:0] wrap_cnt;
  logic             load_err;

  modport master (
    output clr,
    output load,
    output load_val,
    output en,
    input  count,
    input  tc,
    input  wrap,
    input  wrap_cnt,
    input  load_err
  );

  modport slave (
    input  clr,
    input  load,
    input  load_val,
    input  en,
    output count,
    output tc,
    output wrap,
    output wrap_cnt,
    output load_err
  );
endinterface

// File: rtl/up_mod_counter.sv
// Modulo-N up counter with clear, load, wrap pulse,
// saturating wrap counter and out-of-range load flag.
module up_mod_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8,
  parameter int WRAPW   = 8
) (
  input  logic            clk,
  input  logic            reset,
  up_mod_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] LAST =
    WIDTH'(MODULUS - 1);
  localparam logic [32:0] MOD = 33'(MODULUS);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WRAPW-1:0] wcnt_q;
  logic [WRAPW-1:0] wcnt_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             err_q;
  logic             err_d;
  logic             at_last;
  logic             over;

  assign at_last = count_q == LAST;
  // Wide compare: MODULUS == 2**WIDTH can never flag.
  assign over = 33'(bus.load_val) >= MOD;

  always_comb begin
    count_d = count_q;
    wcnt_d  = wcnt_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.clr) begin
      count_d = '0;
      wcnt_d  = '0;
    end else if (bus.load) begin
      if (over) begin
        count_d = LAST;
        err_d   = 1'b1;
      end else begin
        count_d = bus.load_val;
      end
    end else if (bus.en) begin
      if (at_last) begin
        count_d = '0;
        wrap_d  = 1'b1;
        if (!(&wcnt_q)) wcnt_d = wcnt_q + 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wcnt_q  <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wcnt_q  <= wcnt_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.tc       = at_last & bus.en;
  assign bus.wrap     = wrap_q;
  assign bus.wrap_cnt = wcnt_q;
  assign bus.load_err = err_q;
endmodule

// File: tb/tb_up_mod_counter.sv
// Scoreboard bench for up_mod_counter across three
// parameter sets: default, MODULUS=5, WRAPW=2.
module tb_up_mod_counter;
  typedef struct packed {
    logic       tc;
    logic [2:0] count;
    logic       wrap;
    logic [7:0] wc;
    logic       err;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  up_mod_counter_if #(.WIDTH(3), .WRAPW(8)) if0 ();
  up_mod_counter_if #(.WIDTH(3), .WRAPW(8)) if1 ();
  up_mod_counter_if #(.WIDTH(3), .WRAPW(2)) if2 ();

  up_mod_counter #(.WIDTH(3), .MODULUS(8), .WRAPW(8))
    u0 (.clk(clk), .reset(rst_n), .bus(if0));
  up_mod_counter #(.WIDTH(3), .MODULUS(5), .WRAPW(8))
    u1 (.clk(clk), .reset(rst_n), .bus(if1));
  up_mod_counter #(.WIDTH(3), .MODULUS(8), .WRAPW(2))
    u2 (.clk(clk), .reset(rst_n), .bus(if2));

  int nerr = 0;
  int nchk = 0;
  int m_cnt[3];
  int m_wc[3];
  int modv[3] = '{8, 5, 8};
  int wmax[3] = '{255, 255, 3};
  obs_t sb[$];
  obs_t got;
  obs_t e;
  logic got_tc;

  function automatic string fmt(obs_t o);
    return $sformatf("tc=%b cnt=%0d wrap=%b wc=%0d err=%b",
      o.tc, o.count, o.wrap, o.wc, o.err);
  endfunction

  function automatic obs_t sample(int d);
    obs_t o;
    o = '0;
    case (d)
      0: begin
        o.tc = if0.tc; o.count = if0.count;
        o.wrap = if0.wrap; o.wc = if0.wrap_cnt;
        o.err = if0.load_err;
      end
      1: begin
        o.tc = if1.tc; o.count = if1.count;
        o.wrap = if1.wrap; o.wc = if1.wrap_cnt;
        o.err = if1.load_err;
      end
      default: begin
        o.tc = if2.tc; o.count = if2.count;
        o.wrap = if2.wrap; o.wc = 8'(if2.wrap_cnt);
        o.err = if2.load_err;
      end
    endcase
    return o;
  endfunction

  task automatic drive(int d, int c, int l, int v, int en);
    if0.clr = 1'b0; if0.load = 1'b0;
    if0.load_val = 3'd0; if0.en = 1'b0;
    if1.clr = 1'b0; if1.load = 1'b0;
    if1.load_val = 3'd0; if1.en = 1'b0;
    if2.clr = 1'b0; if2.load = 1'b0;
    if2.load_val = 3'd0; if2.en = 1'b0;
    case (d)
      0: begin
        if0.clr = 1'(c); if0.load = 1'(l);
        if0.load_val = 3'(v); if0.en = 1'(en);
      end
      1: begin
        if1.clr = 1'(c); if1.load = 1'(l);
        if1.load_val = 3'(v); if1.en = 1'(en);
      end
      default: begin
        if2.clr = 1'(c); if2.load = 1'(l);
        if2.load_val = 3'(v); if2.en = 1'(en);
      end
    endcase
  endtask

  // One edge: drive, predict, push, then observe.
  task automatic cyc(int d, int c, int l, int v, int en);
    obs_t x;
    x = '0;
    @(negedge clk);
    drive(d, c, l, v, en);
    x.tc = (en != 0) && (m_cnt[d] == modv[d] - 1);
    if (c != 0) begin
      m_cnt[d] = 0;
      m_wc[d] = 0;
    end else if (l != 0) begin
      if (v >= modv[d]) begin
        m_cnt[d] = modv[d] - 1;
        x.err = 1'b1;
      end else begin
        m_cnt[d] = v;
      end
    end else if (en != 0) begin
      if (m_cnt[d] == modv[d] - 1) begin
        m_cnt[d] = 0;
        x.wrap = 1'b1;
        if (m_wc[d] < wmax[d]) m_wc[d]++;
      end else begin
        m_cnt[d]++;
      end
    end
    x.count = 3'(m_cnt[d]);
    x.wc = 8'(m_wc[d]);
    sb.push_back(x);
    #1;
    got_tc = sample(d).tc;
    @(posedge clk);
    #1;
    got = sample(d);
    got.tc = got_tc;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_wc[i] = 0;
    end
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 1);
    #2;
    for (int d = 0; d < 3; d++) begin
      nchk++;
      if (sample(d) !== obs_t'(0)) begin
        nerr++;
        $display("FAIL reset_val d%0d: got %s, want all 0",
          d, fmt(sample(d)));
      end
    end
    #6;
    nchk++;
    if (if0.count !== 3'd0 || if0.tc !== 1'b0) begin
      nerr++;
      $display("FAIL reset_hold: got cnt=%0d tc=%b, want 0 0",
        if0.count, if0.tc);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_count_seq();
    for (int k = 1; k <= 20; k++) begin
      cyc(0, 0, 0, 0, 1);
      e = sb.pop_front();
      nchk++;
      if (got !== e) begin
        nerr++;
        $display("FAIL count_seq %0d: got %s, want %s",
          k, fmt(got), fmt(e));
      end
      nchk++;
      if (got.count !== 3'(k % 8) ||
          got.wrap !== (k % 8 == 0)) begin
        nerr++;
        $display("FAIL seq_const %0d: got cnt=%0d wrap=%b",
          k, got.count, got.wrap);
      end
    end
    nchk++;
    if (got.wc !== 8'd2) begin
      nerr++;
      $display("FAIL seq_wc: got %0d, want 2", got.wc);
    end
  endtask

  task automatic test_tc_gate();
    int en_s[5] = '{1, 1, 1, 0, 1};
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 0, en_s[k]);
      e = sb.pop_front();
      nchk++;
      if (got !== e) begin
        nerr++;
        $display("FAIL tc_gate %0d: got %s, want %s",
          k, fmt(got), fmt(e));
      end
    end
    nchk++;
    if (got.tc !== 1'b1 || got.count !== 3'd0) begin
      nerr++;
      $display("FAIL tc_last: got tc=%b cnt=%0d, want 1 0",
        got.tc, got.count);
    end
  endtask

  task automatic test_load_err();
    cyc(1, 0, 1, 6, 0);
    e = sb.pop_front();
    nchk++;
    if (got !== e || got.count !== 3'd4 || !got.err) begin
      nerr++;
      $display("FAIL load_err: got %s, want %s",
        fmt(got), fmt(e));
    end
    cyc(1, 0, 0, 0, 1);
    e = sb.pop_front();
    nchk++;
    if (got !== e || got.count !== 3'd0 ||
        !got.wrap || got.wc !== 8'd1 || got.err) begin
      nerr++;
      $display("FAIL load_err_wrap: got %s, want %s",
        fmt(got), fmt(e));
    end
    cyc(1, 0, 0, 0, 0);
    e = sb.pop_front();
    nchk++;
    if (got !== e) begin
      nerr++;
      $display("FAIL load_err_idle: got %s, want %s",
        fmt(got), fmt(e));
    end
  endtask

  task automatic test_load_en();
    logic [7:0] wc0;
    cyc(0, 0, 1, 7, 0);
    e = sb.pop_front();
    wc0 = got.wc;
    nchk++;
    if (got !== e) begin
      nerr++;
      $display("FAIL load7: got %s, want %s",
        fmt(got), fmt(e));
    end
    cyc(0, 0, 1, 2, 1);
    e = sb.pop_front();
    nchk++;
    if (got !== e || got.count !== 3'd2 ||
        got.wrap || got.wc !== wc0) begin
      nerr++;
      $display("FAIL load_en: got %s, want %s",
        fmt(got), fmt(e));
    end
  endtask

  task automatic test_clr_prio();
    int d_s[4] = '{0, 0, 1, 1};
    int c_s[4] = '{0, 1, 0, 1};
    int v_s[4] = '{6, 5, 4, 7};
    for (int k = 0; k < 4; k++) begin
      cyc(d_s[k], c_s[k], 1, v_s[k], 1);
      e = sb.pop_front();
      nchk++;
      if (got !== e) begin
        nerr++;
        $display("FAIL clr_prio %0d: got %s, want %s",
          k, fmt(got), fmt(e));
      end
      if (c_s[k] != 0) begin
        nchk++;
        if (got.count !== 3'd0 || got.wc !== 8'd0 ||
            got.err !== 1'b0) begin
          nerr++;
          $display("FAIL clr_const %0d: got %s",
            k, fmt(got));
        end
      end
    end
  endtask

  task automatic test_saturate();
    int pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc(2, 0, 0, 0, 1);
      e = sb.pop_front();
      nchk++;
      if (got !== e) begin
        nerr++;
        $display("FAIL saturate %0d: got %s, want %s",
          k, fmt(got), fmt(e));
      end
      if (got.wrap) pulses++;
    end
    nchk++;
    if (got.wc !== 8'd3 || pulses != 5) begin
      nerr++;
      $display("FAIL sat_final: got wc=%0d pulses=%0d, want 3 5",
        got.wc, pulses);
    end
  endtask

  task automatic reset_release();
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_async_reset();
    int l_s[3] = '{1, 0, 1};
    int v_s[3] = '{7, 0, 5};
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, l_s[k], v_s[k], 1 - l_s[k]);
      e = sb.pop_front();
      nchk++;
      if (got !== e) begin
        nerr++;
        $display("FAIL async_pre %0d: got %s, want %s",
          k, fmt(got), fmt(e));
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    nchk++;
    if (sample(0) !== obs_t'(0) || if2.wrap_cnt !== 2'd0) begin
      nerr++;
      $display("FAIL async_clr: got %s wc2=%0d, want 0",
        fmt(sample(0)), if2.wrap_cnt);
    end
    drive(0, 0, 1, 3, 1);
    repeat (2) @(posedge clk);
    #1;
    nchk++;
    if (if0.count !== 3'd0 || if0.load_err !== 1'b0) begin
      nerr++;
      $display("FAIL async_ignore: got cnt=%0d err=%b",
        if0.count, if0.load_err);
    end
    reset_release();
    cyc(0, 0, 0, 0, 1);
    e = sb.pop_front();
    nchk++;
    if (got !== e || got.count !== 3'd1) begin
      nerr++;
      $display("FAIL resume: got %s, want %s",
        fmt(got), fmt(e));
    end
    cyc(0, 0, 1, 7, 0);
    e = sb.pop_front();
    cyc(0, 0, 0, 0, 1);
    e = sb.pop_front();
    nchk++;
    if (got !== e || !got.wrap) begin
      nerr++;
      $display("FAIL midwrap_pre: got %s, want %s",
        fmt(got), fmt(e));
    end
    #2;
    rst_n = 1'b0;
    #1;
    nchk++;
    if (if0.wrap !== 1'b0 || if0.wrap_cnt !== 8'd0) begin
      nerr++;
      $display("FAIL midwrap_rst: got wrap=%b wc=%0d",
        if0.wrap, if0.wrap_cnt);
    end
    reset_release();
  endtask

  task automatic test_random();
    int c;
    int l;
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 150; k++) begin
        c = ($urandom_range(15) == 0) ? 1 : 0;
        l = ($urandom_range(7) == 0) ? 1 : 0;
        cyc(d, c, l, int'($urandom_range(7)),
          ($urandom_range(3) != 0) ? 1 : 0);
        e = sb.pop_front();
        nchk++;
        if (got !== e) begin
          nerr++;
          $display("FAIL random d%0d %0d: got %s, want %s",
            d, k, fmt(got), fmt(e));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_seq();
    test_tc_gate();
    test_load_err();
    test_load_en();
    test_clr_prio();
    test_saturate();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
